// File: rtl/alu_result_stage.sv
// alu_result_stage: derives Z/N/C/V for each ALU result and queues result+flags toward writeback,
// with a sticky overflow flag and a wrapping accepted-result counter.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_sum,
    input  logic             in_cout,
    input  logic [2:0]       in_op,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [3:0]       out_flags,
    input  logic             clr_sticky,
    output logic             sticky_v,
    output logic [CNT_W-1:0] res_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_data  [DEPTH];
    logic [3:0]    mem_flags [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    last_data;
    logic [3:0]    last_flags;
    logic          push, pop, flag_z, flag_n, flag_c, flag_v;
    logic [3:0]    flags;

    always_comb begin
        flag_z = in_sum == 8'd0;
        flag_n = in_sum[7];
        flag_c = (in_op <= 3'd2) & in_cout;
        // signed overflow depends on which operand is the minuend
        flag_v = in_op == 3'd0 ? (in_a_msb == in_b_msb) && (in_sum[7] != in_a_msb) :
                 in_op == 3'd1 ? (in_a_msb != in_b_msb) && (in_sum[7] != in_a_msb) :
                 in_op == 3'd2 ? (in_a_msb != in_b_msb) && (in_sum[7] != in_b_msb) : 1'b0;
        flags  = {flag_z, flag_n, flag_c, flag_v};
    end

    assign in_ready  = count < (AW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // when empty the outputs show the most recently popped entry
    assign out_data  = out_valid ? mem_data[rd_ptr]  : last_data;
    assign out_flags = out_valid ? mem_flags[rd_ptr] : last_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]  <= '0;
                mem_flags[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_data  <= '0;
            last_flags <= '0;
            sticky_v   <= 1'b0;
            res_cnt    <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr]  <= in_sum;
                mem_flags[wr_ptr] <= flags;
                wr_ptr            <= wr_ptr + AW'(1);
                res_cnt           <= res_cnt + CNT_W'(1);
            end
            if (pop) begin
                last_data  <= mem_data[rd_ptr];
                last_flags <= mem_flags[rd_ptr];
                rd_ptr     <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            sticky_v <= (push && flag_v) ? 1'b1 : clr_sticky ? 1'b0 : sticky_v;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vectors with a scoreboard queue; a negedge monitor checks every pop.
module tb_alu_result_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 0, in_cout = 0, in_a_msb = 0, in_b_msb = 0;
    logic [7:0]  in_sum = 0;
    logic [2:0]  in_op = 0;
    logic        out_ready = 0, clr_sticky = 0;
    logic        in_ready, out_valid, sticky_v;
    logic [7:0]  out_data;
    logic [3:0]  out_flags;
    logic [15:0] res_cnt;

    int          checks = 0, errors = 0;
    logic [11:0] exp_q[$];
    logic [15:0] exp_cnt = 0;
    bit          mon_en = 1;

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .in_cout(in_cout), .in_op(in_op), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
        .clr_sticky(clr_sticky), .sticky_v(sticky_v), .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s, input logic c, input logic [2:0] op,
                        input logic a7, input logic b7, input logic [3:0] f, input logic acc);
        in_valid = 1; in_sum = s; in_cout = c; in_op = op; in_a_msb = a7; in_b_msb = b7;
        @(negedge clk);
        chk("in_ready", in_ready, acc);
        if (acc) begin
            exp_q.push_back({s, f});
            exp_cnt++;
        end
        cycle();
        in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        chk("drain_left", exp_q.size(), 0);
        chk("drain_empty", out_valid, 0);
    endtask

    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %h/%h expected no entry", out_data, out_flags);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", out_data, e[11:4]);
                    chk("pop_flags", out_flags, e[3:0]);
                end
            end
        end
    end

    initial begin
        logic [7:0]  s;
        logic [15:0] cnt0;
        int          n;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_sticky", sticky_v, 0);
        chk("rst_cnt", res_cnt, 0);
        cycle();
        rst_n = 1;
        out_ready = 1;
        send(8'h80, 0, 3'd0, 0, 0, 4'b0101, 1);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 8'h80);
        chk("sticky_set", sticky_v, 1);
        chk("cnt_first", res_cnt, exp_cnt);
        send(8'h00, 1, 3'd1, 1, 1, 4'b1010, 1);
        send(8'h00, 1, 3'd6, 0, 0, 4'b1000, 1);
        send(8'h05, 1, 3'd2, 0, 1, 4'b0011, 1);
        drain();
        chk("hold_data", out_data, 8'h05);
        chk("hold_flags", out_flags, 4'b0011);
        out_ready = 0;
        send(8'h11, 1, 3'd3, 0, 0, 4'b0000, 1);
        send(8'h22, 1, 3'd4, 1, 0, 4'b0000, 1);
        send(8'h33, 1, 3'd7, 0, 1, 4'b0000, 0);
        chk("full_cnt", res_cnt, exp_cnt);
        chk("full_head", out_data, 8'h11);
        out_ready = 1;
        send(8'h44, 0, 3'd0, 0, 0, 4'b0000, 0);
        send(8'h55, 0, 3'd0, 0, 0, 4'b0000, 1);
        cnt0 = exp_cnt;
        for (int i = 0; i < 10; i++) begin
            s = 8'(i * 8'h1D + 8'h7B);
            send(s, 0, 3'd6, 0, 0, {s == 8'h00, s[7], 2'b00}, 1);
            chk("steady_valid", out_valid, 1);
        end
        chk("steady_cnt", res_cnt, 16'(cnt0 + 16'd10));
        drain();
        clr_sticky = 1;
        cycle();
        clr_sticky = 0;
        chk("sticky_clr", sticky_v, 0);
        clr_sticky = 1;
        send(8'h90, 0, 3'd1, 0, 1, 4'b0101, 1);
        chk("sticky_set_wins", sticky_v, 1);
        send(8'h01, 0, 3'd3, 0, 0, 4'b0000, 1);
        clr_sticky = 0;
        chk("sticky_clr_push", sticky_v, 0);
        drain();
        mon_en = 0;
        in_valid = 1; in_sum = 8'h00; in_op = 3'd3;
        n = 32'hFFFF - int'(exp_cnt);
        repeat (n) @(posedge clk);
        #1;
        in_valid = 0;
        repeat (3) cycle();
        exp_cnt = 16'hFFFF;
        chk("cnt_max", res_cnt, exp_cnt);
        chk("bulk_empty", out_valid, 0);
        mon_en = 1;
        send(8'h7F, 0, 3'd0, 0, 0, 4'b0000, 1);
        chk("cnt_wrap", res_cnt, 16'h0000);
        drain();
        out_ready = 0;
        send(8'hA1, 0, 3'd0, 0, 0, 4'b0101, 1);
        send(8'hB2, 0, 3'd0, 0, 0, 4'b0101, 1);
        chk("pre_rst_sticky", sticky_v, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_cnt", res_cnt, 0);
        chk("arst_sticky", sticky_v, 0);
        chk("arst_out_data", out_data, 0);
        exp_q.delete();
        exp_cnt = 0;
        cycle();
        rst_n = 1;
        out_ready = 1;
        send(8'h3C, 0, 3'd6, 0, 0, 4'b0000, 1);
        drain();
        chk("post_rst_cnt", res_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
